cpu_wb_bridge: RTL and testbench
================================

CPU_WB_BRIDGE -- requirements
Module: cpu_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of bus cycles to wait for ack/err (8-bit counter range).
REQ-002 SHALL have ports in this order (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  CPU load/store request; single-cycle pulse, sampled in IDLE only.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code (LB/LH/LW/LBU/LHU/SB/SH/SW).
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load result, extended; 0 for stores and errors.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error flag, coincident with done.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone B4 classic controls.
- wb_adr_o  out  32  word-aligned address.
- wb_dat_o  out  32  lane-steered write data.
- wb_sel_o  out  4  byte lane selects.
- wb_dat_i  in  32  slave read data.
- wb_ack_i, wb_err_i  in  1 each  slave termination.

Function
REQ-003 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; all outputs registered.
REQ-004 In IDLE with req=1: SHALL latch we/funct3/addr/wdata; legal request -> BUS with cyc/stb asserted next cycle; illegal request -> RESP, no bus cycle.
REQ-005 Illegal request SHALL mean: funct3 in {3,6,7}; store funct3 >= 3; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-006 wb_adr_o SHALL equal {addr[31:2],2'b00}; wb_we_o SHALL equal the latched we.
REQ-007 wb_sel_o SHALL be: byte 4'b0001<<addr[1:0]; halfword 4'b0011<<addr[1:0]; word 4'b1111.
REQ-008 wb_dat_o SHALL replicate the byte (x4) or halfword (x2) across lanes; word is passed through.
REQ-009 In BUS: cyc/stb/adr/sel/dat SHALL be held stable until ack or err is sampled high, then deasserted the next cycle (-> RESP).
REQ-010 ack and err high in the same cycle SHALL be treated as err.
REQ-011 Load rdata SHALL select the addressed lane of wb_dat_i: LB/LH sign-extend, LBU/LHU zero-extend, LW raw; it is captured on ack.
REQ-012 RESP SHALL pulse done for exactly one cycle, with err=1 on slave error, timeout or illegal request; then return to IDLE.
REQ-013 Latency: req in cycle N, stb in N+1, ack in cycle M, done in M+1; a zero-wait slave gives done at N+2. An illegal request gives done at N+1.
REQ-014 req SHALL be ignored in BUS and RESP, with no queueing.
REQ-015 rdata SHALL hold its value until the next done.

Reset
REQ-016 reset low SHALL immediately force state IDLE and drive all outputs to 0, including wb_cyc_o/wb_stb_o mid-cycle; the timeout counter clears; no done is generated for an aborted transfer.

Configuration
REQ-017 With macro CPU_WB_BRIDGE_TIMEOUT_EN defined: the counter SHALL increment each BUS cycle, and reaching TIMEOUT_CYCLES without ack/err drops cyc/stb and ends in RESP with err=1.
REQ-018 Without CPU_WB_BRIDGE_TIMEOUT_EN: BUS SHALL wait indefinitely, no counter SHALL be synthesised, and TIMEOUT_CYCLES is unused.

Structure
REQ-019 Shared package wb_pkg SHALL hold the FSM state enum, the funct3 constants (LB..SW), and the width constants for address, data and sel.
REQ-020 Sub-module lsu_align (combinational) SHALL compute sel, write-lane steering, read extraction/extension and the misalignment flag; the bridge instantiates it once.

Verification
REQ-021 LW addr 0x100, slave acks after 3 wait states with 0xDEADBEEF -> sel=F, adr=0x100, rdata=0xDEADBEEF, done 1 cycle after ack, err=0.
REQ-022 SB addr 0x203, wdata 0xA5 -> sel=4'b1000, wb_dat_o=0xA5A5A5A5, we=1, done with rdata=0.
REQ-023 LB addr 0x301, wb_dat_i 0x0000_8000 -> rdata 0xFFFFFF80; LBU at the same address -> rdata 0x00000080.
REQ-024 LH addr 0x401 -> no cyc/stb ever, done+err at N+1; slave asserting ack and err together -> done with err=1.
REQ-025 Timeout build, TIMEOUT_CYCLES=4, slave silent -> cyc drops after 4 BUS cycles, done+err; non-timeout build -> cyc remains high.
REQ-026 reset low during BUS -> cyc/stb 0 asynchronously, no done; the next req after release completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the CPU-to-Wishbone load/store bridge.
//   state_t        : bridge FSM states
//   F3_*           : RISC-V load/store width codes
//   ADDR_W/DATA_W/SEL_W : bus widths
//   funct3_legal() : width code is valid for the access direction
package wb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Stores only have SB/SH/SW; loads have no codes 3, 6 or 7.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 < 3'd3);
        else
            return !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the bridge.
//   funct3    in  width code (bit 2 = unsigned load)
//   offset    in  addr[1:0]
//   wdata     in  right-aligned store data
//   bus_rdata in  raw Wishbone read word
//   sel       out byte lane selects
//   bus_wdata out store data replicated across lanes
//   rdata     out addressed lane, sign/zero extended
//   misalign  out access not naturally aligned
module lsu_align
    import wb_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign
);

    logic [DATA_W-1:0] shifted;

    // Addressed lane moved down to bit 0.
    assign shifted = bus_rdata >> {offset, 3'b000};

    always_comb begin
        sel       = 4'b1111;
        bus_wdata = wdata;
        rdata     = bus_rdata;
        misalign  = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                sel       = 4'b0001 << offset;
                bus_wdata = {4{wdata[7:0]}};
                rdata     = funct3[2] ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                sel       = 4'b0011 << offset;
                bus_wdata = {2{wdata[15:0]}};
                rdata     = funct3[2] ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
                misalign  = offset[0];
            end
            default: begin
                misalign  = |offset;
            end
        endcase
    end

endmodule

// File: rtl/cpu_wb_bridge.sv
// Single-outstanding CPU load/store to Wishbone B4 classic bridge.
//   clk, reset (async, active low)
//   req/we/funct3/addr/wdata : CPU request, sampled in IDLE only
//   rdata/done/err           : registered completion (done/err one cycle)
//   wb_*                     : Wishbone master port, all outputs registered
// Build option: define CPU_WB_BRIDGE_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles without ack/err; otherwise the bus waits forever.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for req
// BUS     | cyc/stb high, waiting for ack/err (or timeout)
// RESP    | done pulse, err for slave error/timeout/illegal
module cpu_wb_bridge
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    state_t            state_q, state_d;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;

    logic [2:0]        al_funct3;
    logic [1:0]        al_off;
    logic [SEL_W-1:0]  al_sel;
    logic [DATA_W-1:0] al_wdat, al_rdat;
    logic              al_misalign;

    logic              req_ok, bus_end, timeout;

    logic              cyc_d, we_d, done_d, err_d;
    logic [ADDR_W-1:0] adr_d;
    logic [SEL_W-1:0]  sel_d;
    logic [DATA_W-1:0] dat_d, rdata_d;

    // One aligner serves both phases: live request in IDLE, latched
    // request while reading the slave data in BUS.
    assign al_funct3 = (state_q == ST_IDLE) ? funct3 : funct3_q;
    assign al_off    = (state_q == ST_IDLE) ? addr[1:0] : off_q;

    lsu_align u_align (
        .funct3    (al_funct3),
        .offset    (al_off),
        .wdata     (wdata),
        .bus_rdata (wb_dat_i),
        .sel       (al_sel),
        .bus_wdata (al_wdat),
        .rdata     (al_rdat),
        .misalign  (al_misalign)
    );

    assign req_ok  = funct3_legal(we, funct3) && !al_misalign;
    assign bus_end = wb_ack_i || wb_err_i || timeout;

`ifdef CPU_WB_BRIDGE_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // Counter holds the number of BUS cycles already completed.
    assign timeout = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_cnt_q <= 8'd0;
        else if (state_q == ST_BUS)
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        else
            tmo_cnt_q <= 8'd0;
    end
`else
    // No timeout hardware; the parameter is referenced only so both
    // builds share one interface.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            off_q    <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            state_q  <= state_d;
            wb_cyc_o <= cyc_d;
            wb_stb_o <= cyc_d;
            wb_we_o  <= we_d;
            wb_adr_o <= adr_d;
            wb_sel_o <= sel_d;
            wb_dat_o <= dat_d;
            done     <= done_d;
            err      <= err_d;
            rdata    <= rdata_d;
            if (state_q == ST_IDLE && req) begin
                funct3_q <= funct3;
                off_q    <= addr[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = req_ok ? ST_BUS : ST_RESP;
            ST_BUS:  if (bus_end) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cyc_d   = wb_cyc_o;
        we_d    = wb_we_o;
        adr_d   = wb_adr_o;
        sel_d   = wb_sel_o;
        dat_d   = wb_dat_o;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_ok) begin
                        cyc_d = 1'b1;
                        we_d  = we;
                        adr_d = {addr[ADDR_W-1:2], 2'b00};
                        sel_d = al_sel;
                        dat_d = al_wdat;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_BUS: begin
                if (bus_end) begin
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    adr_d  = '0;
                    sel_d  = '0;
                    dat_d  = '0;
                    done_d = 1'b1;
                    // err wins over ack; no ack at all means timeout.
                    err_d   = wb_err_i || !wb_ack_i;
                    rdata_d = (wb_ack_i && !wb_err_i && !wb_we_o) ? al_rdat : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_wb_bridge.sv
module tb_cpu_wb_bridge;

`ifdef CPU_WB_BRIDGE_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, wb_adr_o, wb_dat_o, wb_dat_i;
    logic        done, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, wb_err_i;
    logic [3:0]  wb_sel_o;

    cpu_wb_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_legal(input bit w, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (w && f3 >= 3'd3) return 1'b0;
        if ((int'(a[1:0]) % m_size(f3)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s = '0;
        for (int i = 0; i < m_size(f3); i++) s[int'(a[1:0]) + i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdat(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = '0;
        for (int lane = 0; lane < 4; lane++)
            r[8*lane +: 8] = wd[8*(lane % m_size(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v = '0;
        int sz = m_size(f3);
        for (int k = 0; k < sz; k++) v[8*k +: 8] = d[8*(int'(a[1:0]) + k) +: 8];
        if (!f3[2] && sz < 4)
            for (int b = 8*sz; b < 32; b++) v[b] = v[8*sz-1];
        return v;
    endfunction

    // ---------------- expectations and compare ----------------
    logic        e_cyc = 0, e_done = 0, e_err = 0, e_we = 0;
    logic [31:0] e_adr = 0, e_dat = 0, m_rdata = 0;
    logic [3:0]  e_sel = 0;

    always @(negedge clk) begin
        check("cyc",   32'(wb_cyc_o), 32'(e_cyc));
        check("stb",   32'(wb_stb_o), 32'(e_cyc));
        check("done",  32'(done),     32'(e_done));
        check("err",   32'(err),      32'(e_err));
        check("rdata", rdata,         m_rdata);
        if (e_cyc) begin
            check("adr", wb_adr_o,        e_adr);
            check("sel", 32'(wb_sel_o),   32'(e_sel));
            check("dat", wb_dat_o,        e_dat);
            check("we",  32'(wb_we_o),    32'(e_we));
        end
    end

    // Snapshot monitor for the hand-computed directed checks.
    int          cyc_no = 0;
    int          req_cyc, last_done_cyc, n_dones = 0, n_cyc_hi = 0;
    logic        last_done_err;
    logic [31:0] last_adr, last_dat;
    logic [3:0]  last_sel;
    logic        last_we;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    always @(negedge clk) begin
        if (wb_cyc_o) begin
            n_cyc_hi++;
            last_adr = wb_adr_o; last_dat = wb_dat_o;
            last_sel = wb_sel_o; last_we = wb_we_o;
        end
        if (done) begin
            n_dones++;
            last_done_cyc = cyc_no;
            last_done_err = err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic scramble();
        req    = 1'($urandom_range(0, 1));
        we     = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom_range(0, 7));
        addr   = $urandom;
        wdata  = $urandom;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // mode: 0 ack, 1 err, 2 ack+err; resp_at = BUS cycle of response, 0 = never
    task automatic txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int resp_at, input int mode,
                       input logic [31:0] rd);
        bit ok, fin, is_err;
        int c;
        ok = m_legal(w, f3, a); fin = 0; is_err = 0; c = 0;
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd; req_cyc = cyc_no;
        e_cyc = 0; e_done = 0; e_err = 0;
        @(posedge clk); #1;
        scramble();
        if (!ok) begin
            e_done = 1; e_err = 1; m_rdata = '0;
        end else begin
            e_cyc = 1; e_we = w; e_adr = {a[31:2], 2'b00};
            e_sel = m_sel(f3, a); e_dat = m_wdat(f3, wd);
            while (!fin) begin
                c++;
                wb_ack_i = 0; wb_err_i = 0; wb_dat_i = $urandom;
                if (c == resp_at) begin
                    fin = 1; is_err = (mode != 0);
                    wb_ack_i = (mode != 1); wb_err_i = (mode != 0); wb_dat_i = rd;
                end else if (TMO_EN && c == TMO) begin
                    fin = 1; is_err = 1;
                end else if (c >= 300) begin
                    fin = 1;
                end
                @(posedge clk); #1;
                scramble();
            end
            wb_ack_i = 0; wb_err_i = 0; wb_dat_i = $urandom;
            e_cyc = 0; e_done = 1; e_err = is_err;
            m_rdata = (is_err || w) ? '0 : m_rd(f3, a, rd);
        end
        @(posedge clk); #1;
        req = 1'b0; e_done = 0; e_err = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0, n_hold;
        reset = 0; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cyc",   32'(wb_cyc_o), 0);
        check("rst_done",  32'(done), 0);
        check("rst_rdata", rdata, 0);
        check("rst_sel",   32'(wb_sel_o), 0);
        check("rst_adr",   wb_adr_o, 0);
        reset = 1;
        @(posedge clk); #1;

        // LW, three wait states
        txn(0, 3'd2, 32'h100, 32'h0, 4, 0, 32'hDEADBEEF);
        check("lw_sel",     32'(last_sel), 32'hF);
        check("lw_adr",     last_adr, 32'h100);
        check("lw_rdata",   rdata, 32'hDEADBEEF);
        check("lw_latency", last_done_cyc - req_cyc, 5);
        check("lw_err",     32'(last_done_err), 0);

        // SB, zero-wait slave
        txn(1, 3'd0, 32'h203, 32'hA5, 1, 0, 32'h12345678);
        check("sb_sel",     32'(last_sel), 32'h8);
        check("sb_dat",     last_dat, 32'hA5A5A5A5);
        check("sb_we",      32'(last_we), 1);
        check("sb_rdata",   rdata, 0);
        check("sb_latency", last_done_cyc - req_cyc, 2);

        // LB / LBU extension
        txn(0, 3'd0, 32'h301, 32'h0, 2, 0, 32'h00008000);
        check("lb_rdata",  rdata, 32'hFFFFFF80);
        txn(0, 3'd4, 32'h301, 32'h0, 1, 0, 32'h00008000);
        check("lbu_rdata", rdata, 32'h00000080);

        // misaligned LH: no bus cycle
        n_cyc_hi = 0;
        txn(0, 3'd1, 32'h401, 32'h0, 1, 0, 32'h0);
        check("lh_mis_nocyc",   n_cyc_hi, 0);
        check("lh_mis_latency", last_done_cyc - req_cyc, 1);
        check("lh_mis_err",     32'(last_done_err), 1);

        // ack and err together
        txn(0, 3'd2, 32'h404, 32'h0, 2, 2, 32'hCAFEF00D);
        check("ackerr_err",   32'(last_done_err), 1);
        check("ackerr_rdata", rdata, 0);

`ifdef CPU_WB_BRIDGE_TIMEOUT_EN
        n_cyc_hi = 0;
        txn(0, 3'd2, 32'h500, 32'h0, 0, 0, 32'h0);
        check("tmo_cyc_cycles", n_cyc_hi, 4);
        check("tmo_latency",    last_done_cyc - req_cyc, 5);
        check("tmo_err",        32'(last_done_err), 1);
        n_hold = 2;
`else
        n_hold = 20;
`endif

        // reset mid-bus: silent slave, cyc stays high until reset
        idle(1);
        d0 = n_dones;
        req = 1; we = 0; funct3 = 3'd2; addr = 32'h600; wdata = 32'h0;
        @(posedge clk); #1;
        req = 0;
        e_cyc = 1; e_we = 0; e_adr = 32'h600; e_sel = 4'hF; e_dat = m_wdat(3'd2, 32'h0);
        repeat (n_hold - 1) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        reset = 0; e_cyc = 0; e_done = 0; m_rdata = '0;
        #1;
        check("abort_cyc", 32'(wb_cyc_o), 0);
        check("abort_stb", 32'(wb_stb_o), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        idle(3);
        check("abort_no_done", n_dones - d0, 0);
        txn(0, 3'd1, 32'h702, 32'h0, 1, 0, 32'h80010000);
        check("post_abort_rdata", rdata, 32'hFFFF8001);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom_range(1, 6),
                ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0, $urandom);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
